// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan
// Scanned, double-buffered driver for a DIGITS-wide seven-segment display.
// Rev    : 1.0
// ============================================================================
module sevenseg_scan #(
    parameter int DIGITS     = 4,
    parameter int DIV        = 50000,
    parameter int HEX        = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int              c_PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int              c_IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST   = c_PW'(DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(DIGITS - 1);
    localparam logic            c_INV        = (ACTIVE_LOW != 0);

    logic [c_PW-1:0]       r_presc;
    logic [c_IW-1:0]       r_idx;
    logic [4*DIGITS-1:0]   r_act_data;
    logic [DIGITS-1:0]     r_act_dp;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend;
    logic                  r_frame_done;
    logic [6:0]            r_seg;
    logic                  r_dp_out;
    logic [DIGITS-1:0]     r_an;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic [DIGITS-1:0]     w_hi_zero;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic [DIGITS-1:0]     w_an;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (HEX == 0 && n > 4'd9) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    assign w_tick      = en && (r_presc == c_PRE_LAST);
    assign w_frame_end = w_tick && (r_idx == c_IDX_LAST);

    // w_hi_zero[i]: every active nibble from i up to the top digit is zero
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
        assign w_hi_zero[gi] = (r_act_data[4*DIGITS-1:4*gi] == '0);
    end

    assign w_nib   = r_act_data[{r_idx, 2'b00} +: 4];
    assign w_dp    = r_act_dp[r_idx];
    assign w_blank = blank_lz && (r_idx != '0) && w_hi_zero[r_idx];
    assign w_seg   = w_blank ? 7'b0000000 : f_glyph(w_nib);

    always_comb begin
        w_an        = '0;
        w_an[r_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend       <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= {7{c_INV}};
            r_dp_out     <= c_INV;
            r_an         <= {DIGITS{c_INV}};
        end else begin
            if (en) begin
                r_presc <= (r_presc == c_PRE_LAST) ? '0 : r_presc + 1'b1;
            end
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            r_frame_done <= w_frame_end;

            if (load) begin
                r_pend_data <= data;
                r_pend_dp   <= dp;
            end
            // A load coinciding with the frame boundary bypasses the pending stage
            if (w_frame_end && load) begin
                r_act_data <= data;
                r_act_dp   <= dp;
                r_pend     <= 1'b0;
            end else if (w_frame_end && r_pend) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_pend     <= 1'b0;
            end else if (load) begin
                r_pend     <= 1'b1;
            end

            if (en) begin
                r_seg    <= w_seg ^ {7{c_INV}};
                r_dp_out <= w_dp ^ c_INV;
                r_an     <= w_an ^ {DIGITS{c_INV}};
            end else begin
                r_seg    <= {7{c_INV}};
                r_dp_out <= c_INV;
                r_an     <= {DIGITS{c_INV}};
            end
        end
    end

    assign segments   = r_seg;
    assign dp_out     = r_dp_out;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_sevenseg_scan
// Directed bench for sevenseg_scan: hex/decimal and active-high/low variants.
// Rev    : 1.0
// ============================================================================
module tb_sevenseg_scan;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blank_lz;

    logic [6:0]  w_seg_a, w_seg_b, w_seg_c;
    logic        w_dp_a, w_dp_b, w_dp_c;
    logic [3:0]  w_an_a, w_an_b, w_an_c;
    logic        w_fd_a, w_fd_b, w_fd_c;

    int total = 0;
    int bad   = 0;

    sevenseg_scan #(.DIGITS(4), .DIV(4), .HEX(1), .ACTIVE_LOW(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .segments(w_seg_a), .dp_out(w_dp_a), .an(w_an_a),
        .frame_done(w_fd_a)
    );

    sevenseg_scan #(.DIGITS(4), .DIV(4), .HEX(0), .ACTIVE_LOW(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .segments(w_seg_b), .dp_out(w_dp_b), .an(w_an_b),
        .frame_done(w_fd_b)
    );

    sevenseg_scan #(.DIGITS(4), .DIV(4), .HEX(1), .ACTIVE_LOW(1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .segments(w_seg_c), .dp_out(w_dp_c), .an(w_an_c),
        .frame_done(w_fd_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        load = 1'b1;
        data = d;
        dp   = p;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (w_fd_a !== 1'b1 && n < 64);
        chk({tag, "_fd"}, {15'd0, w_fd_a}, 16'd1);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an_a"},  {12'd0, w_an_a},  16'h0000);
        chk({tag, "_seg_a"}, {9'd0, w_seg_a},  16'h0000);
        chk({tag, "_dp_a"},  {15'd0, w_dp_a},  16'h0000);
        chk({tag, "_an_c"},  {12'd0, w_an_c},  16'h000F);
        chk({tag, "_seg_c"}, {9'd0, w_seg_c},  16'h007F);
        chk({tag, "_dp_c"},  {15'd0, w_dp_c},  16'h0001);
    endtask

    // Called right at a frame_done sample; checks the middle of every slot.
    task automatic check_frame(input string tag, input logic [27:0] seg_a_exp,
                               input logic [27:0] seg_b_exp, input logic [3:0] dp_exp,
                               input int load_slot, input logic [15:0] ld_data);
        step(2);
        chk({tag, "_fd_pulse"}, {15'd0, w_fd_a}, 16'd0);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] ea;
            logic [6:0] es;
            ea = 4'b0001 << s;
            es = seg_a_exp[7*s +: 7];
            chk($sformatf("%s_s%0d_an_a", tag, s),  {12'd0, w_an_a}, {12'd0, ea});
            chk($sformatf("%s_s%0d_seg_a", tag, s), {9'd0, w_seg_a}, {9'd0, es});
            chk($sformatf("%s_s%0d_dp_a", tag, s),  {15'd0, w_dp_a}, {15'd0, dp_exp[s]});
            chk($sformatf("%s_s%0d_seg_b", tag, s), {9'd0, w_seg_b}, {9'd0, seg_b_exp[7*s +: 7]});
            chk($sformatf("%s_s%0d_an_c", tag, s),  {12'd0, w_an_c}, {12'd0, ~ea});
            chk($sformatf("%s_s%0d_seg_c", tag, s), {9'd0, w_seg_c}, {9'd0, ~es});
            chk($sformatf("%s_s%0d_dp_c", tag, s),  {15'd0, w_dp_c}, {15'd0, ~dp_exp[s]});
            if (s == load_slot) begin
                load_word(ld_data, 4'b0000);
            end
            if (s < 3) begin
                step(4);
            end
        end
    endtask

    // Slot glyphs packed {slot3, slot2, slot1, slot0}
    localparam logic [27:0] c_F1234 = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
    localparam logic [27:0] c_F5678 = {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};
    localparam logic [27:0] c_FABCD = {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101};
    localparam logic [27:0] c_F0070 = {7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110};
    localparam logic [27:0] c_F0000 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110};

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        data     = 16'h0000;
        dp       = 4'b0000;
        blank_lz = 1'b0;

        step(2);
        chk_dark("reset");
        chk("reset_fd", {15'd0, w_fd_a}, 16'd0);
        reset_n = 1'b1;

        load_word(16'h1234, 4'b0000);
        en = 1'b1;
        wait_frame("f0");
        check_frame("d1234", c_F1234, c_F1234, 4'b0000, -1, 16'h0000);

        wait_frame("f1");
        check_frame("tear", c_F1234, c_F1234, 4'b0000, 2, 16'h5678);
        wait_frame("f2");
        check_frame("d5678", c_F5678, c_F5678, 4'b0000, -1, 16'h0000);

        // load lands exactly on the frame_end edge
        step(1);
        load = 1'b1;
        data = 16'hABCD;
        dp   = 4'b0000;
        step(1);
        load = 1'b0;
        chk("coinc_fd", {15'd0, w_fd_a}, 16'd1);
        check_frame("hex", c_FABCD, 28'd0, 4'b0000, -1, 16'h0000);

        blank_lz = 1'b1;
        step(1);
        load_word(16'h0070, 4'b1000);
        wait_frame("f4");
        check_frame("lz70", c_F0070, c_F0070, 4'b1000, -1, 16'h0000);

        step(1);
        load_word(16'h0000, 4'b0000);
        wait_frame("f5");
        check_frame("lz00", c_F0000, c_F0000, 4'b0000, -1, 16'h0000);

        blank_lz = 1'b0;
        wait_frame("f6");
        step(2);
        en = 1'b0;
        step(1);
        chk_dark("dis1");
        step(9);
        chk_dark("dis10");
        chk("dis_fd", {15'd0, w_fd_a}, 16'd0);
        en = 1'b1;
        step(1);
        chk("resume_an0", {12'd0, w_an_a}, 16'h0001);
        step(1);
        chk("resume_an1", {12'd0, w_an_a}, 16'h0001);
        step(1);
        chk("resume_an2", {12'd0, w_an_a}, 16'h0002);
        chk("resume_seg", {9'd0, w_seg_a}, 16'h007E);

        step(2);
        reset_n = 1'b0;
        #1;
        chk_dark("midrst");
        chk("midrst_fd", {15'd0, w_fd_a}, 16'd0);
        #3;
        reset_n = 1'b1;
        step(1);
        chk("post_an_a",  {12'd0, w_an_a},  16'h0001);
        chk("post_seg_a", {9'd0, w_seg_a},  16'h007E);
        chk("post_dp_a",  {15'd0, w_dp_a},  16'h0000);
        chk("post_an_c",  {12'd0, w_an_c},  16'h000E);
        chk("post_seg_c", {9'd0, w_seg_c},  16'h0001);
        chk("post_fd",    {15'd0, w_fd_a},  16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
